ram2e_ufm_writer: RTL and testbench
===================================

Name: ram2e_ufm_writer

Overview:
Hardware sequencer that saves the RAMWorks capacity mask and LED setting into the MAX II/V UFM, replacing host bitbang. It is the writer counterpart of the power-up settings reader. It encodes one 16-bit settings word and shifts it into the UFM data register. When the sector is full it erases and rewinds the address register, then issues program and waits out busy. It drives the UFM primitive's control pins and is muxed against the reader by the top level, which grants the UFM pins while Busy=1.

Parameters:
CLKDIV, 2, C14M cycles per DRCLK/ARCLK half-period (≥1); keeps UFM clocks ≤ 3.6 MHz at 14.318 MHz.
ADDRW, 9, UFM address register width (number of zero shifts on rewind).
TIMEOUT, 24'd2000000, max C14M cycles to wait for busy to clear (~140 ms).

Ports:
C14M  in  1  system clock, 14.318 MHz
Rst  in  1  synchronous, active-high reset
SaveReq  in  1  one-cycle request; ignored while Busy
SaveMask  in  8  RWMask value to store (sampled on accepted SaveReq)
SaveLED  in  1  LEDEN value to store (sampled on accepted SaveReq)
ReqErase  in  1  sector full; erase and rewind before programming (sampled on accept)
UFMBusy  in  1  UFM busy, asynchronous
RTPBusy  in  1  real-time-programming busy, asynchronous
ARCLK  out  1  UFM address register clock
ARShift  out  1  1 = shift address, 0 = increment
DRCLK  out  1  UFM data register clock
DRDIn  out  1  UFM data register serial input
DRShift  out  1  1 = shift, 0 = parallel load
UFMErase  out  1  UFM sector erase (rising edge active)
UFMProgram  out  1  UFM program (rising edge active)
Busy  out  1  sequence in progress
Done  out  1  one-cycle pulse at sequence end
Err  out  1  sticky; busy timeout or verify failure; cleared by the next accepted SaveReq

Behaviour:
- Reset: all outputs 0, state IDLE, Err=0, timeout counter 0.
- UFMBusy and RTPBusy are OR'd, then passed through a 2-flop synchroniser (BusyS).
- Encoding, W[15:0]:
  - W[15:8] = {SaveMask[7], ~SaveMask[6:0]}. If SaveMask==8'h80, W[15:8]=8'h80, so 0xFF is never written (0xFF marks an erased byte).
  - W[7] = SaveLED ^ W[15].
  - W[6:0] = 7'h7F.
- SaveReq is accepted only in IDLE. On accept: latch W and ReqErase, set Busy=1 and Err=0, go to WAITIDLE.
- Tick: a divider counter produces a tick every CLKDIV cycles. All UFM clock edges and data changes occur on ticks only.
- States:
  - WAITIDLE: wait for BusyS=0, then go to ERASE if ReqErase was latched, else LOAD.
  - ERASE: UFMErase=1 for 1 cycle, then ERASEWAIT.
  - ERASEWAIT: wait for BusyS to rise, then fall. Then REWIND.
  - REWIND: ARShift=1, DRDIn don't-care. ADDRW ARCLK pulses (low tick, high tick) shift in zeros (ardin is tied 0 at top). Then LOAD.
  - LOAD: DRShift=1. 16 DRCLK pulses, MSB first. DRDIn is set up on the low tick and clocked on the high tick. Then PROG.
  - PROG: UFMProgram=1 for 1 cycle, then PROGWAIT.
  - PROGWAIT: wait for BusyS to rise, then fall. Then DONE.
  - DONE: Done=1 for 1 cycle, Busy=0, go to IDLE.
- ARCLK and DRCLK idle low. ARShift and DRShift return to 0 in IDLE.
- Timeout: in WAITIDLE, ERASEWAIT and PROGWAIT, a counter runs. Reaching TIMEOUT sets Err=1, drops UFMErase/UFMProgram, and returns to IDLE via DONE (Done still pulses).
- Busy never rising within TIMEOUT after a command is also a timeout.
- SaveReq while Busy: dropped with no effect.
- Rst mid-sequence: immediate return to IDLE with all outputs 0. An in-flight UFM operation completes on its own; the next save waits for it in WAITIDLE.

Optional Feature:
RAM2E_UFM_WRITER_VERIFY_EN. When defined, PROGWAIT goes to VERIFY instead of DONE:
- VERIFY pulses DRCLK once with DRShift=0 (parallel load from the current address).
- It then shifts 16 bits with DRShift=1, sampling DRDOut on each high tick, and compares the result to W.
- A mismatch sets Err.
- Adds input DRDOut (1 bit); the port exists only when the macro is defined.

When undefined: no read-back and no DRDOut port.

Decomposition:
- Package ram2e_ufm_pkg:
  - state enum
  - UFM_ERASED_BYTE = 8'hFF and MASK_ALIAS = 8'h80
  - encode function mask/LED → W
  - shared with the reader's decode
- One sub-module, ram2e_ufm_clkgen: tick divider plus low/high phase and pulse counter, used by REWIND, LOAD and VERIFY.

Test Plan:
- Mask 8'h3F, LED 1, ReqErase 0, BusyS idle → no ARCLK; DRDIn serial stream 16'h40FF (MSB first) over 16 DRCLK pulses; then one UFMProgram pulse. With busy model 50 cycles high → Done pulse, Err=0.
- Mask 8'h80, LED 0 → W=16'h80FF (the 0xFF marker is never written).
- ReqErase 1 → UFMErase pulse; after busy falls, exactly 9 ARCLK pulses with ARShift=1; then LOAD and PROG in order.
- Busy model never rises after PROG → Err=1 and Done after TIMEOUT (override TIMEOUT=1000), Busy=0.
- Rst asserted mid-LOAD (after bit 5) → next cycle all outputs 0. A new SaveReq completes normally.
- VERIFY_EN: read-back model returns W with bit 3 flipped → Err=1. Correct read-back → Err=0.

Source files
------------

// File: rtl/ram2e_ufm_pkg.sv
// Shared definitions for the RAM2E UFM settings writer and reader.
// Contents: sequencer state enum, settings-word constants and the
// mask/LED -> 16-bit UFM word encoder.
package ram2e_ufm_pkg;

  localparam int unsigned UFM_WORDW = 16;
  localparam int unsigned PCNTW     = 16;

  localparam logic [7:0] UFM_ERASED_BYTE = 8'hFF;
  localparam logic [7:0] MASK_ALIAS      = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAITIDLE,
    ST_ERASE,
    ST_ERASEWAIT,
    ST_REWIND,
    ST_LOAD,
    ST_PROG,
    ST_PROGWAIT,
    ST_VERIFY,
    ST_DONE
  } ufm_wr_state_t;

  // High byte stores the mask with bits 6:0 inverted; the one value that
  // would produce the erased-byte marker is aliased so 0xFF never lands in UFM.
  // LED is stored relative to the mask MSB; the low seven bits stay erased.
  function automatic logic [UFM_WORDW-1:0] ufm_encode(input logic [7:0] mask,
                                                      input logic       led);
    logic [7:0] hi;
    hi = {mask[7], ~mask[6:0]};
    if (hi == UFM_ERASED_BYTE) hi = MASK_ALIAS;
    return {hi, led ^ hi[7], 7'h7F};
  endfunction

endpackage

// File: rtl/ram2e_ufm_clkgen.sv
// Tick divider and pulse sequencer for the UFM serial clocks.
// After i_start, emits i_count low/high tick pairs (one per clock pulse)
// followed by a final low tick (o_fin_c) that returns the clock low.
// Ports:
//   i_clk, i_rst   system clock, synchronous active-high reset
//   i_start        one-cycle start strobe, latches i_count
//   i_count        number of clock pulses to generate
//   o_low_c        tick where the serial clock goes/stays low (data setup)
//   o_high_c       tick where the serial clock rises (data capture)
//   o_fin_c        closing low tick after the last pulse
module ram2e_ufm_clkgen
  import ram2e_ufm_pkg::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PCNTW-1:0] i_count,
  output logic             o_low_c,
  output logic             o_high_c,
  output logic             o_fin_c
);

  localparam int unsigned DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic            r_run;
  logic            r_phase;   // 0: next tick is low, 1: next tick is high
  logic [DIVW-1:0] r_div;
  logic [PCNTW-1:0] r_cnt;    // pulses still to be issued
  logic            w_tick;

  assign w_tick   = r_run && (r_div == DIVW'(CLKDIV - 1));
  assign o_low_c  = w_tick && !r_phase && (r_cnt != '0);
  assign o_high_c = w_tick &&  r_phase;
  assign o_fin_c  = w_tick && !r_phase && (r_cnt == '0);

  // Divider restarts on every start so the first tick is a full period out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run   <= 1'b0;
      r_phase <= 1'b0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_phase <= 1'b0;
      r_div   <= '0;
      r_cnt   <= i_count;
    end else if (r_run) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (r_phase) begin
          r_phase <= 1'b0;
          r_cnt   <= r_cnt - 1'b1;
        end else if (r_cnt == '0) begin
          r_run <= 1'b0;
        end else begin
          r_phase <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram2e_ufm_writer.sv
// RAM2E UFM settings writer: encodes RWMask/LEDEN into one 16-bit word,
// optionally erases the sector and rewinds the address register, shifts the
// word into the UFM data register and programs it, waiting out UFM busy.
// Optional read-back verify: define RAM2E_UFM_WRITER_VERIFY_EN (adds DRDOut).
// Ports:
//   C14M, Rst                 clock, synchronous active-high reset
//   SaveReq/SaveMask/SaveLED  save request and settings to store
//   ReqErase                  erase + rewind before programming
//   UFMBusy, RTPBusy          asynchronous UFM busy flags
//   ARCLK, ARShift            UFM address register controls
//   DRCLK, DRDIn, DRShift     UFM data register controls
//   UFMErase, UFMProgram      UFM command strobes
//   Busy, Done, Err           sequencer status
//   DRDOut                    UFM data out (verify build only)
module ram2e_ufm_writer
  import ram2e_ufm_pkg::*;
#(
  parameter int unsigned CLKDIV  = 2,
  parameter int unsigned ADDRW   = 9,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic       C14M,
  input  logic       Rst,
  input  logic       SaveReq,
  input  logic [7:0] SaveMask,
  input  logic       SaveLED,
  input  logic       ReqErase,
  input  logic       UFMBusy,
  input  logic       RTPBusy,
  output logic       ARCLK,
  output logic       ARShift,
  output logic       DRCLK,
  output logic       DRDIn,
  output logic       DRShift,
  output logic       UFMErase,
  output logic       UFMProgram,
  output logic       Busy,
  output logic       Done,
  output logic       Err
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
  ,
  input  logic       DRDOut
`endif
);

  ufm_wr_state_t        r_state;
  logic [1:0]           r_bsync;
  logic [UFM_WORDW-1:0] r_w;
  logic [UFM_WORDW-1:0] r_sh;
  logic                 r_req_erase;
  logic                 r_seen;      // busy observed high after a command
  logic [23:0]          r_tmo;
  logic                 r_cg_start;
  logic [PCNTW-1:0]     r_cg_count;
  logic                 r_arclk, r_arshift, r_drclk, r_drdin, r_drshift;
  logic                 r_erase, r_prog, r_busy, r_done, r_err;
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
  logic                 r_vphase;    // 0: parallel-load pulse, 1: shift-out
  logic [UFM_WORDW-1:0] r_rd;
`endif

  logic w_busys;
  logic w_tmo_hit;
  logic w_cg_low, w_cg_high, w_cg_fin;

  assign w_busys   = r_bsync[1];
  assign w_tmo_hit = (r_tmo == TIMEOUT);

  ram2e_ufm_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .i_clk    (C14M),
    .i_rst    (Rst),
    .i_start  (r_cg_start),
    .i_count  (r_cg_count),
    .o_low_c  (w_cg_low),
    .o_high_c (w_cg_high),
    .o_fin_c  (w_cg_fin)
  );

  assign ARCLK      = r_arclk;
  assign ARShift    = r_arshift;
  assign DRCLK      = r_drclk;
  assign DRDIn      = r_drdin;
  assign DRShift    = r_drshift;
  assign UFMErase   = r_erase;
  assign UFMProgram = r_prog;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Err        = r_err;

  // Sequencer; every output is a register updated on state transitions/ticks
  always_ff @(posedge C14M) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_bsync     <= '0;
      r_w         <= '0;
      r_sh        <= '0;
      r_req_erase <= 1'b0;
      r_seen      <= 1'b0;
      r_tmo       <= '0;
      r_cg_start  <= 1'b0;
      r_cg_count  <= '0;
      r_arclk     <= 1'b0;
      r_arshift   <= 1'b0;
      r_drclk     <= 1'b0;
      r_drdin     <= 1'b0;
      r_drshift   <= 1'b0;
      r_erase     <= 1'b0;
      r_prog      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
      r_vphase    <= 1'b0;
      r_rd        <= '0;
`endif
    end else begin
      r_bsync    <= {r_bsync[0], UFMBusy | RTPBusy};
      r_cg_start <= 1'b0;
      r_done     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (SaveReq) begin
            r_w         <= ufm_encode(SaveMask, SaveLED);
            r_req_erase <= ReqErase;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_tmo       <= '0;
            r_state     <= ST_WAITIDLE;
          end
        end

        // Let any operation left over from before a reset finish first
        ST_WAITIDLE: begin
          if (!w_busys) begin
            if (r_req_erase) begin
              r_erase <= 1'b1;
              r_state <= ST_ERASE;
            end else begin
              r_drshift  <= 1'b1;
              r_sh       <= r_w;
              r_cg_count <= PCNTW'(UFM_WORDW);
              r_cg_start <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 24'd1;
          end
        end

        ST_ERASE: begin
          r_erase <= 1'b0;
          r_seen  <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_ERASEWAIT;
        end

        ST_ERASEWAIT: begin
          if (w_tmo_hit) begin
            r_erase <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 24'd1;
            if (w_busys) begin
              r_seen <= 1'b1;
            end else if (r_seen) begin
              r_arshift  <= 1'b1;
              r_cg_count <= PCNTW'(ADDRW);
              r_cg_start <= 1'b1;
              r_state    <= ST_REWIND;
            end
          end
        end

        // Address input is tied low at the top, so each pulse shifts in a zero
        ST_REWIND: begin
          if (w_cg_low)  r_arclk <= 1'b0;
          if (w_cg_high) r_arclk <= 1'b1;
          if (w_cg_fin) begin
            r_arclk    <= 1'b0;
            r_arshift  <= 1'b0;
            r_drshift  <= 1'b1;
            r_sh       <= r_w;
            r_cg_count <= PCNTW'(UFM_WORDW);
            r_cg_start <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end

        // MSB first: data set up on the low tick, clocked on the high tick
        ST_LOAD: begin
          if (w_cg_low) begin
            r_drclk <= 1'b0;
            r_drdin <= r_sh[UFM_WORDW-1];
            r_sh    <= {r_sh[UFM_WORDW-2:0], 1'b0};
          end
          if (w_cg_high) r_drclk <= 1'b1;
          if (w_cg_fin) begin
            r_drclk   <= 1'b0;
            r_drdin   <= 1'b0;
            r_drshift <= 1'b0;
            r_prog    <= 1'b1;
            r_state   <= ST_PROG;
          end
        end

        ST_PROG: begin
          r_prog  <= 1'b0;
          r_seen  <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_PROGWAIT;
        end

        ST_PROGWAIT: begin
          if (w_tmo_hit) begin
            r_prog  <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 24'd1;
            if (w_busys) begin
              r_seen <= 1'b1;
            end else if (r_seen) begin
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
              r_vphase   <= 1'b0;
              r_drshift  <= 1'b0;
              r_cg_count <= PCNTW'(1);
              r_cg_start <= 1'b1;
              r_state    <= ST_VERIFY;
`else
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
`endif
            end
          end
        end

`ifdef RAM2E_UFM_WRITER_VERIFY_EN
        // One parallel-load pulse, then 16 shift pulses sampling DRDOut
        ST_VERIFY: begin
          if (w_cg_low) r_drclk <= 1'b0;
          if (w_cg_high) begin
            r_drclk <= 1'b1;
            if (r_vphase) r_rd <= {r_rd[UFM_WORDW-2:0], DRDOut};
          end
          if (w_cg_fin) begin
            r_drclk <= 1'b0;
            if (!r_vphase) begin
              r_vphase   <= 1'b1;
              r_drshift  <= 1'b1;
              r_cg_count <= PCNTW'(UFM_WORDW);
              r_cg_start <= 1'b1;
            end else begin
              r_drshift <= 1'b0;
              if (r_rd != r_w) r_err <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
`endif

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2e_ufm_writer.sv
// Directed self-checking bench for ram2e_ufm_writer (TIMEOUT shortened).
module tb_ram2e_ufm_writer;

  logic       C14M = 1'b0;
  logic       Rst = 1'b1;
  logic       SaveReq = 1'b0;
  logic [7:0] SaveMask = 8'h00;
  logic       SaveLED = 1'b0;
  logic       ReqErase = 1'b0;
  logic       UFMBusy;
  logic       RTPBusy = 1'b0;
  logic       ARCLK, ARShift, DRCLK, DRDIn, DRShift;
  logic       UFMErase, UFMProgram, Busy, Done, Err;
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
  logic       DRDOut;
  logic [15:0] rb_val = 16'h0000;
  logic [15:0] rb = 16'h0000;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ram2e_ufm_writer #(
    .CLKDIV  (2),
    .ADDRW   (9),
    .TIMEOUT (24'd1000)
  ) dut (
    .C14M       (C14M),
    .Rst        (Rst),
    .SaveReq    (SaveReq),
    .SaveMask   (SaveMask),
    .SaveLED    (SaveLED),
    .ReqErase   (ReqErase),
    .UFMBusy    (UFMBusy),
    .RTPBusy    (RTPBusy),
    .ARCLK      (ARCLK),
    .ARShift    (ARShift),
    .DRCLK      (DRCLK),
    .DRDIn      (DRDIn),
    .DRShift    (DRShift),
    .UFMErase   (UFMErase),
    .UFMProgram (UFMProgram),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err)
`ifdef RAM2E_UFM_WRITER_VERIFY_EN
    ,
    .DRDOut     (DRDOut)
`endif
  );

  always #5 C14M = ~C14M;

  // UFM busy model: 3 cycles after a command edge, busy high for bm_len cycles
  logic bm_en = 1'b1;
  int   bm_len = 50;
  int   bm_dly = 0;
  int   bm_left = 0;
  logic prev_cmd = 1'b0;
  always @(posedge C14M) begin
    prev_cmd <= UFMErase | UFMProgram;
    if (bm_en && (UFMErase | UFMProgram) && !prev_cmd) bm_dly <= 3;
    else if (bm_dly > 0) begin
      bm_dly <= bm_dly - 1;
      if (bm_dly == 1) bm_left <= bm_len;
    end else if (bm_left > 0) bm_left <= bm_left - 1;
  end
  assign UFMBusy = (bm_left > 0);

`ifdef RAM2E_UFM_WRITER_VERIFY_EN
  always @(posedge DRCLK) begin
    if (!DRShift) rb <= rb_val;
    else          rb <= {rb[14:0], 1'b0};
  end
  assign DRDOut = rb[15];
`endif

  // Free-running monitors; tests work on differences from a snapshot
  int arclk_n = 0, arsh_n = 0, drclk_n = 0, erase_n = 0, prog_n = 0;
  int arclk_at_dr = 0, arclk_at_erase = 0, drclk_at_prog = 0;
  logic [15:0] sr = 16'h0000;
  logic [15:0] sr_at_prog = 16'h0000;
  always @(posedge ARCLK) begin
    arclk_n <= arclk_n + 1;
    if (ARShift) arsh_n <= arsh_n + 1;
  end
  always @(posedge DRCLK) begin
    drclk_n <= drclk_n + 1;
    arclk_at_dr <= arclk_n;
    if (DRShift) sr <= {sr[14:0], DRDIn};
  end
  always @(posedge UFMErase) begin
    erase_n <= erase_n + 1;
    arclk_at_erase <= arclk_n;
  end
  always @(posedge UFMProgram) begin
    prog_n <= prog_n + 1;
    drclk_at_prog <= drclk_n;
    sr_at_prog <= sr;
  end

  int b_ar, b_arsh, b_dr, b_er, b_pr;
  logic seen, d_err, d_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ar = arclk_n; b_arsh = arsh_n; b_dr = drclk_n; b_er = erase_n; b_pr = prog_n;
  endtask

  task automatic start_save(input logic [7:0] m, input logic l, input logic e);
    @(negedge C14M);
    SaveMask = m; SaveLED = l; ReqErase = e; SaveReq = 1'b1;
    @(negedge C14M);
    SaveReq = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    seen = 1'b0; d_err = 1'bx; d_busy = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge C14M);
      if (Done) begin seen = 1'b1; d_err = Err; d_busy = Busy; end
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({ARCLK, ARShift, DRCLK, DRDIn, DRShift, UFMErase, UFMProgram, Busy, Done, Err});
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge C14M);
    check("reset_outputs", outs(), 32'h0);
    Rst = 1'b0;

    // Mask 3F, LED 1, no erase -> W = 40FF; a SaveReq mid-sequence is dropped
    snap();
    start_save(8'h3F, 1'b1, 1'b0);
    check("t1_busy_after_accept", 32'(Busy), 32'h1);
    repeat (20) @(negedge C14M);
    SaveMask = 8'h00; SaveLED = 1'b0; ReqErase = 1'b1; SaveReq = 1'b1;
    @(negedge C14M);
    SaveReq = 1'b0; ReqErase = 1'b0;
    wait_done(3000);
    check("t1_done_seen", 32'(seen), 32'h1);
    check("t1_err", 32'(d_err), 32'h0);
    check("t1_busy_at_done", 32'(d_busy), 32'h0);
    check("t1_stream", 32'(sr_at_prog), 32'h40FF);
    check("t1_drclk_pulses", 32'(drclk_at_prog - b_dr), 32'd16);
    check("t1_arclk_pulses", 32'(arclk_n - b_ar), 32'd0);
    check("t1_prog_pulses", 32'(prog_n - b_pr), 32'd1);
    check("t1_erase_pulses", 32'(erase_n - b_er), 32'd0);

    // Mask 80 must not produce the erased-byte marker -> W = 80FF
    snap();
    start_save(8'h80, 1'b0, 1'b0);
    wait_done(3000);
    check("t2_done_seen", 32'(seen), 32'h1);
    check("t2_stream", 32'(sr_at_prog), 32'h80FF);
    check("t2_err", 32'(d_err), 32'h0);

    // Erase + rewind: mask 01, LED 0 -> W = 7E7F
    snap();
    start_save(8'h01, 1'b0, 1'b1);
    wait_done(4000);
    check("t3_done_seen", 32'(seen), 32'h1);
    check("t3_erase_pulses", 32'(erase_n - b_er), 32'd1);
    check("t3_arclk_before_erase", 32'(arclk_at_erase - b_ar), 32'd0);
    check("t3_arclk_pulses", 32'(arclk_n - b_ar), 32'd9);
    check("t3_arshift_pulses", 32'(arsh_n - b_arsh), 32'd9);
    check("t3_arclk_before_load", 32'(arclk_at_dr - b_ar), 32'd9);
    check("t3_drclk_pulses", 32'(drclk_at_prog - b_dr), 32'd16);
    check("t3_stream", 32'(sr_at_prog), 32'h7E7F);
    check("t3_prog_pulses", 32'(prog_n - b_pr), 32'd1);
    check("t3_err", 32'(d_err), 32'h0);

    // Busy never rises after program -> timeout, Err sticky
    bm_en = 1'b0;
    start_save(8'h3F, 1'b1, 1'b0);
    wait_done(5000);
    check("t4_done_seen", 32'(seen), 32'h1);
    check("t4_err", 32'(d_err), 32'h1);
    check("t4_busy_at_done", 32'(d_busy), 32'h0);
    repeat (5) @(negedge C14M);
    check("t4_err_sticky", 32'(Err), 32'h1);
    check("t4_prog_low", 32'(UFMProgram), 32'h0);
    bm_en = 1'b1;

    // Next accept clears Err; reset mid-LOAD after bit 5
    snap();
    start_save(8'h3F, 1'b1, 1'b0);
    check("t5_err_cleared", 32'(Err), 32'h0);
    begin
      int k;
      k = 0;
      while ((drclk_n - b_dr) < 6 && k < 2000) begin @(negedge C14M); k++; end
      check("t5_reached_bit5", 32'(k < 2000), 32'h1);
    end
    Rst = 1'b1;
    @(posedge C14M);
    #1;
    check("t5_outputs_after_rst", outs(), 32'h0);
    @(negedge C14M);
    Rst = 1'b0;
    snap();
    start_save(8'h3F, 1'b1, 1'b0);
    wait_done(3000);
    check("t5_done_seen", 32'(seen), 32'h1);
    check("t5_stream", 32'(sr_at_prog), 32'h40FF);
    check("t5_drclk_pulses", 32'(drclk_at_prog - b_dr), 32'd16);
    check("t5_err", 32'(d_err), 32'h0);

`ifdef RAM2E_UFM_WRITER_VERIFY_EN
    // Read-back with bit 3 flipped -> Err; correct read-back -> no Err
    rb_val = 16'h40FF ^ 16'h0008;
    start_save(8'h3F, 1'b1, 1'b0);
    wait_done(3000);
    check("v_bad_done_seen", 32'(seen), 32'h1);
    check("v_bad_err", 32'(d_err), 32'h1);
    rb_val = 16'h40FF;
    start_save(8'h3F, 1'b1, 1'b0);
    wait_done(3000);
    check("v_ok_done_seen", 32'(seen), 32'h1);
    check("v_ok_err", 32'(d_err), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
